// File: rtl/period_meter_if.sv
// Control/result bundle of the period meter.
// slave = the meter; master = whoever requests measurements and reads periods.
interface period_meter_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             start;
  logic             busy;
  logic             valid;
  logic             timeout;
  logic [CNT_W-1:0] period;

  modport master (
    output start,
    input  busy,
    input  valid,
    input  timeout,
    input  period
  );

  modport slave (
    input  start,
    output busy,
    output valid,
    output timeout,
    output period
  );
endinterface

// File: rtl/period_meter.sv
// Measures the period of a slow asynchronous signal in clk_in cycles (rise-to-rise).
// Define PERIOD_METER_CONT_EN for back-to-back measurements; default is one-shot.
module period_meter #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 3100000
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          sig_in,
  period_meter_if.slave pm
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ArmMax = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StArm, StMeasure} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       sync_q;
  logic             hist_q;
  logic [1:0]       warm_q;
  logic             rise;

  // Edge detection is masked until the history flop has seen settled synchronizer output.
  assign rise = sync_q[1] & ~hist_q & (warm_q == 2'd3);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      sync_q    <= 2'b00;
      hist_q    <= 1'b0;
      warm_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      sync_q    <= {sync_q[0], sig_in};
      hist_q    <= sync_q[1];
      if (warm_q != 2'd3) begin
        warm_q <= warm_q + 2'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A rise coinciding with start is not an opening edge.
        if (pm.start) begin
          state_d = StArm;
          tcnt_d  = '0;
        end
      end
      StArm: begin
        if (rise) begin
          state_d = StMeasure;
          cnt_d   = CntOne;
          tcnt_d  = '0;
        end else if (tcnt_q == ArmMax) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + CntOne;
        end
      end
      StMeasure: begin
        if (rise) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
`ifdef PERIOD_METER_CONT_EN
          // Closing edge doubles as the opening edge of the next period.
          cnt_d    = CntOne;
`else
          state_d  = StIdle;
`endif
        end else if (cnt_q == CntMax) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pm.busy    = (state_q != StIdle);
  assign pm.valid   = valid_q;
  assign pm.timeout = timeout_q;
  assign pm.period  = period_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: expected results are queued at stimulus time
// and popped by a monitor when valid/timeout fire. Timeout is scaled down to keep runs short.
module tb_period_meter;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned TO    = 3100;
`ifdef PERIOD_METER_CONT_EN
  localparam bit ContEn = 1'b1;
`else
  localparam bit ContEn = 1'b0;
`endif

  typedef struct packed {
    logic             is_to;
    logic [CNT_W-1:0] per;
    logic [31:0]      at;     // expected event cycle, 0 = don't care
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic        sig_in = 1'b1;
  logic        gen_en = 1'b0;
  int          half   = 101;
  int          gcnt   = 0;
  logic [31:0] cyc    = '0;
  logic [31:0] last_evt = '0;
  logic [31:0] x;
  logic [31:0] arm_cyc;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_valid  = 0;
  exp_t        sb[$];
  exp_t        mon_e;

  period_meter_if #(.CNT_W(CNT_W)) pm ();

  period_meter #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .pm     (pm)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic exp_t mk(input logic t, input logic [CNT_W-1:0] p, input logic [31:0] a);
    mk.is_to = t;
    mk.per   = p;
    mk.at    = a;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk_in);
    end
    check("scoreboard_drained", 64'(sb.size()), 0);
  endtask

  task automatic pulse_start();
    @(posedge clk_in);
    #1 pm.start = 1'b1;
    @(posedge clk_in);
    #1 pm.start = 1'b0;
  endtask

  // Divided-clock model: toggles every 'half' cycles while enabled.
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      if (gen_en) begin
        if (gcnt >= half - 1) begin
          sig_in = ~sig_in;
          gcnt   = 0;
        end else begin
          gcnt++;
        end
      end
    end
  end

  always @(negedge clk_in) begin
    if (rst_n && (pm.valid || pm.timeout)) begin
      last_evt = cyc;
      if (pm.valid) n_valid++;
      check("valid_timeout_exclusive", 64'(pm.valid & pm.timeout), 0);
      if (sb.size() == 0) begin
        check("unexpected_event", 64'({pm.valid, pm.timeout}), 0);
      end else begin
        mon_e = sb.pop_front();
        check("event_is_timeout", 64'(pm.timeout), 64'(mon_e.is_to));
        check("period", 64'(pm.period), 64'(mon_e.per));
        check("busy_at_event", 64'(pm.busy), 64'(!mon_e.is_to && ContEn));
        if (mon_e.at != 0) check("event_cycle", 64'(cyc), 64'(mon_e.at));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pm.start = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("reset_busy", 64'(pm.busy), 0);
    check("reset_valid", 64'(pm.valid), 0);
    check("reset_timeout", 64'(pm.timeout), 0);
    check("reset_period", 64'(pm.period), 0);

`ifdef PERIOD_METER_CONT_EN
    @(posedge clk_in);
    #1 rst_n = 1'b1;
    gen_en = 1'b1;
    @(posedge sig_in);
    x = cyc;
    @(posedge clk_in);
    @(posedge clk_in);
    #1 pm.start = 1'b1;
    @(posedge clk_in);
    #1 pm.start = 1'b0;
    for (int k = 0; k < 5; k++) sb.push_back(mk(1'b0, 202, x + 407 + 202 * k));
    wait_empty(1500);
    gen_en = 1'b0;
    sb.push_back(mk(1'b1, 202, 0));
    wait_empty(TO + 500);
    check("cont_valid_count", 64'(n_valid), 5);
    check("cont_idle_after_timeout", 64'(pm.busy), 0);
`else
    // Release with sig_in high and start at once: the warm-up must hide the level.
    @(posedge clk_in);
    #1 rst_n = 1'b1;
    pm.start = 1'b1;
    gen_en   = 1'b1;
    @(posedge clk_in);
    #1 pm.start = 1'b0;
    sb.push_back(mk(1'b0, 202, 0));
    @(negedge clk_in);
    check("busy_armed", 64'(pm.busy), 1);
    @(posedge sig_in);
    x = cyc;
    wait_empty(1000);
    check("first_result_cycle", 64'(last_evt), 64'(x + 205));
    repeat (600) @(negedge clk_in);
    check("one_valid_per_start", 64'(n_valid), 1);

    // Slow divider ratio.
    half = 1501;
    pulse_start();
    sb.push_back(mk(1'b0, 3002, 0));
    wait_empty(8000);

    // Constant input: timeout exactly TO cycles after ARM entry.
    gen_en = 1'b0;
    pulse_start();
    arm_cyc = cyc;
    sb.push_back(mk(1'b1, 3002, arm_cyc + TO));
    wait_empty(TO + 100);
    @(negedge clk_in);
    check("idle_after_timeout", 64'(pm.busy), 0);
    check("period_held_after_timeout", 64'(pm.period), 3002);

    // Start on the same cycle as a rise in IDLE, then start again mid-measurement.
    half   = 101;
    gen_en = 1'b1;
    @(posedge sig_in);
    x = cyc;
    @(posedge clk_in);
    @(posedge clk_in);
    #1 pm.start = 1'b1;
    @(posedge clk_in);
    #1 pm.start = 1'b0;
    sb.push_back(mk(1'b0, 202, x + 407));
    repeat (300) @(posedge clk_in);
    #1 pm.start = 1'b1;
    @(posedge clk_in);
    #1 pm.start = 1'b0;
    wait_empty(600);

    // Reset in the middle of MEASURE.
    @(posedge sig_in);
    @(posedge clk_in);
    #1 pm.start = 1'b1;
    @(posedge clk_in);
    #1 pm.start = 1'b0;
    repeat (100) @(posedge clk_in);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(pm.busy), 0);
    check("midrst_valid", 64'(pm.valid), 0);
    check("midrst_timeout", 64'(pm.timeout), 0);
    check("midrst_period", 64'(pm.period), 0);
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1'b1;
    pm.start = 1'b1;
    @(posedge clk_in);
    #1 pm.start = 1'b0;
    sb.push_back(mk(1'b0, 202, 0));
    wait_empty(1000);
    check("valid_total", 64'(n_valid), 4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
